// File: rtl/tt_pkg.sv
// ---------------------------------------------------------------------------
// tt_pkg
// Shared definitions for the ball dispenser:
//   state_t       - dispenser FSM state encoding
//   CAUSE_*       - o_halt_cause codes (none / intercepted / empty / timeout)
//   cnt_width()   - width of a ball counter able to hold max(a, b)
// ---------------------------------------------------------------------------
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_IN_FLIGHT = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_INTERCEPT = 2'd1;
    localparam logic [1:0] CAUSE_EMPTY     = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'd3;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/ball_dispenser_if.sv
// ---------------------------------------------------------------------------
// ball_dispenser_if
// Board-side signal bundle of the ball dispenser.
//   i_start_left/right  - start buttons (asynchronous levels)
//   i_trig_left/right   - bottom levers (asynchronous levels)
//   i_intercepted       - OR of all interceptor occupied flags
//   o_ball_blue/red     - ball pulses into the top ramps
//   o_blue_cnt/red_cnt  - balls remaining per colour (CW bits)
//   o_in_flight, o_halt, o_halt_cause - game status
// Modports: slave = dispenser side, master = board / test side.
// ---------------------------------------------------------------------------
interface ball_dispenser_if #(
    parameter int CW = 4
);
    logic          i_start_left;
    logic          i_start_right;
    logic          i_trig_left;
    logic          i_trig_right;
    logic          i_intercepted;
    logic          o_ball_blue;
    logic          o_ball_red;
    logic [CW-1:0] o_blue_cnt;
    logic [CW-1:0] o_red_cnt;
    logic          o_in_flight;
    logic          o_halt;
    logic [1:0]    o_halt_cause;

    modport slave (
        input  i_start_left, i_start_right, i_trig_left, i_trig_right, i_intercepted,
        output o_ball_blue, o_ball_red, o_blue_cnt, o_red_cnt,
               o_in_flight, o_halt, o_halt_cause
    );

    modport master (
        output i_start_left, i_start_right, i_trig_left, i_trig_right, i_intercepted,
        input  o_ball_blue, o_ball_red, o_blue_cnt, o_red_cnt,
               o_in_flight, o_halt, o_halt_cause
    );
endinterface

// File: rtl/tt_edge_sync.sv
// ---------------------------------------------------------------------------
// tt_edge_sync
// Two-flop synchroniser followed by a rising-edge detector.
//   clk     - sole clock
//   rst_n   - asynchronous active-low reset (clears all flops)
//   i_async - asynchronous level input
//   o_rise  - one-cycle pulse on a synchronised 0->1 transition
// Clearing r_prev in reset means a level held high through reset is seen
// as a fresh rising edge once reset is released.
// ---------------------------------------------------------------------------
module tt_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/ball_dispenser.sv
// ---------------------------------------------------------------------------
// ball_dispenser
// Releases blue/red balls onto the board on start/lever requests, tracks
// remaining balls and stops the game on interception, empty colour or a
// ball that never reaches a lever.
//   clk   - sole clock
//   rst_n - asynchronous active-low reset
//   bus   - ball_dispenser_if.slave (all board-side inputs and outputs)
// Parameters: N_BLUE/N_RED initial counts, PULSE_LEN release pulse width,
// TIMEOUT maximum cycles a ball may stay in flight.
// ---------------------------------------------------------------------------
module ball_dispenser
    import tt_pkg::*;
#(
    parameter int N_BLUE    = 8,
    parameter int N_RED     = 8,
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    ball_dispenser_if.slave   bus
);
    localparam int CW = cnt_width(N_BLUE, N_RED);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    // Input order: 0 start_left, 1 trig_left, 2 start_right, 3 trig_right
    logic [3:0] w_async;
    logic [3:0] w_rise;

    assign w_async = {bus.i_trig_right, bus.i_start_right, bus.i_trig_left, bus.i_start_left};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            tt_edge_sync u_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_async (w_async[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    state_t          r_state;
    logic [CW-1:0]   r_blue_cnt;
    logic [CW-1:0]   r_red_cnt;
    logic [PW-1:0]   r_pulse_cnt;
    logic [WW-1:0]   r_wd_cnt;
    logic            r_ball_blue;
    logic            r_ball_red;
    logic            r_in_flight;
    logic            r_halt;
    logic [1:0]      r_halt_cause;

    logic            w_req_left;
    logic            w_req_right;
    logic            w_accept;
    logic            w_flight;
    logic            w_take_blue;
    logic            w_take_red;
    logic            w_halt_req;
    logic [1:0]      w_cause;

    assign w_req_left  = w_rise[0] | w_rise[1];
    assign w_req_right = w_rise[2] | w_rise[3];
    assign w_flight    = (r_state == ST_IN_FLIGHT);
    assign w_accept    = (r_state == ST_IDLE) || w_flight;

    // Decision priority: interception, then left request (a simultaneous
    // right request is dropped), then right request, then watchdog expiry.
    always_comb begin
        w_take_blue = 1'b0;
        w_take_red  = 1'b0;
        w_halt_req  = 1'b0;
        w_cause     = CAUSE_NONE;
        if (w_flight && bus.i_intercepted) begin
            w_halt_req = 1'b1;
            w_cause    = CAUSE_INTERCEPT;
        end else if (w_accept && w_req_left) begin
            if (r_blue_cnt != '0) begin
                w_take_blue = 1'b1;
            end else begin
                w_halt_req = 1'b1;
                w_cause    = CAUSE_EMPTY;
            end
        end else if (w_accept && w_req_right) begin
            if (r_red_cnt != '0) begin
                w_take_red = 1'b1;
            end else begin
                w_halt_req = 1'b1;
                w_cause    = CAUSE_EMPTY;
            end
        end else if (w_flight && (r_wd_cnt == WD_LAST)) begin
            w_halt_req = 1'b1;
            w_cause    = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_blue_cnt   <= CW'(N_BLUE);
            r_red_cnt    <= CW'(N_RED);
            r_pulse_cnt  <= '0;
            r_wd_cnt     <= '0;
            r_ball_blue  <= 1'b0;
            r_ball_red   <= 1'b0;
            r_in_flight  <= 1'b0;
            r_halt       <= 1'b0;
            r_halt_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_IDLE, ST_IN_FLIGHT: begin
                    if (w_halt_req) begin
                        r_state      <= ST_HALT;
                        r_halt       <= 1'b1;
                        r_halt_cause <= w_cause;
                        r_in_flight  <= 1'b0;
                    end else if (w_take_blue) begin
                        r_state     <= ST_RELEASE;
                        r_blue_cnt  <= r_blue_cnt - CW'(1);
                        r_ball_blue <= 1'b1;
                        r_in_flight <= 1'b1;
                        r_pulse_cnt <= '0;
                    end else if (w_take_red) begin
                        r_state     <= ST_RELEASE;
                        r_red_cnt   <= r_red_cnt - CW'(1);
                        r_ball_red  <= 1'b1;
                        r_in_flight <= 1'b1;
                        r_pulse_cnt <= '0;
                    end else if (w_flight) begin
                        r_wd_cnt <= r_wd_cnt + WW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        r_state     <= ST_IN_FLIGHT;
                        r_ball_blue <= 1'b0;
                        r_ball_red  <= 1'b0;
                        r_wd_cnt    <= '0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + PW'(1);
                    end
                end
                ST_HALT: begin
                    r_ball_blue <= 1'b0;
                    r_ball_red  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ball_blue  = r_ball_blue;
    assign bus.o_ball_red   = r_ball_red;
    assign bus.o_blue_cnt   = r_blue_cnt;
    assign bus.o_red_cnt    = r_red_cnt;
    assign bus.o_in_flight  = r_in_flight;
    assign bus.o_halt       = r_halt;
    assign bus.o_halt_cause = r_halt_cause;
endmodule

// File: tb/tb_ball_dispenser.sv
// ---------------------------------------------------------------------------
// tb_ball_dispenser
// Randomised + directed stimulus against a game-level reference model.
// The driver predicts each observable event (ball release or halt) with its
// cycle, counts and cause and queues it; the monitor pops and compares when
// the dispenser presents the event.
// ---------------------------------------------------------------------------
module tb_ball_dispenser;
    localparam int N_BLUE    = 8;
    localparam int N_RED     = 8;
    localparam int PULSE_LEN = 4;
    localparam int TIMEOUT   = 16;
    localparam int CW = $clog2(((N_BLUE > N_RED) ? N_BLUE : N_RED) + 1);
    localparam int EV_BLUE = 0, EV_RED = 1, EV_HALT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_dispenser_if #(.CW(CW)) bus ();

    ball_dispenser #(
        .N_BLUE(N_BLUE), .N_RED(N_RED), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int blue;
        int red;
        int cause;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    function automatic string ev_name(input int k);
        return (k == EV_BLUE) ? "blue" : (k == EV_RED) ? "red" : "halt";
    endfunction

    // ---------------- reference model (game level) ----------------
    int m_blue, m_red, m_fall;
    bit m_halted, m_flying;

    task automatic model_reset();
        m_blue = N_BLUE; m_red = N_RED; m_halted = 0; m_flying = 0; m_fall = 0;
    endtask

    task automatic push_exp(input int kind, input int c, input int cause);
        exp_t e;
        e.kind = kind; e.cyc = c; e.blue = m_blue; e.red = m_red; e.cause = cause;
        exp_q.push_back(e);
    endtask

    // side 0 = left, 1 = right, 2 = both (left wins). An input raised in the
    // cycle numbered c produces its response three cycles later.
    task automatic predict_request(input int side, input int c);
        if (m_halted) return;
        if (side != 1) begin
            if (m_blue > 0) begin
                m_blue--; push_exp(EV_BLUE, c + 3, 0);
                m_flying = 1; m_fall = c + 3 + PULSE_LEN;
            end else begin
                push_exp(EV_HALT, c + 3, 2); m_halted = 1; m_flying = 0;
            end
        end else begin
            if (m_red > 0) begin
                m_red--; push_exp(EV_RED, c + 3, 0);
                m_flying = 1; m_fall = c + 3 + PULSE_LEN;
            end else begin
                push_exp(EV_HALT, c + 3, 2); m_halted = 1; m_flying = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.i_start_left = 0; bus.i_start_right = 0;
        bus.i_trig_left = 0; bus.i_trig_right = 0; bus.i_intercepted = 0;
    endtask

    task automatic request(input int side, input bit use_trig);
        @(negedge clk);
        predict_request(side, cyc);
        if (side != 1) begin
            if (use_trig) bus.i_trig_left = 1; else bus.i_start_left = 1;
        end
        if (side != 0) begin
            if (use_trig) bus.i_trig_right = 1; else bus.i_start_right = 1;
        end
        repeat (2) @(negedge clk);
        clear_inputs();
    endtask

    // Wait until the current ball has left the release phase, plus a gap.
    task automatic wait_flight(input int gap);
        if (m_halted) return;
        for (int i = 0; i < 200 && cyc < m_fall; i++) @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    task automatic intercept_with_trig();
        @(negedge clk);
        if (!m_halted && m_flying) begin
            push_exp(EV_HALT, cyc + 1, 1); m_halted = 1; m_flying = 0;
        end
        bus.i_intercepted = 1; bus.i_trig_left = 1;
        repeat (2) @(negedge clk);
        clear_inputs();
    endtask

    task automatic wait_timeout();
        push_exp(EV_HALT, m_fall + TIMEOUT, 3); m_halted = 1; m_flying = 0;
        for (int i = 0; i < 400 && cyc < m_fall + TIMEOUT + 2; i++) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1; model_reset();
    endtask

    // ---------------- monitor ----------------
    bit p_blue, p_red, p_halt;
    int plen_b, plen_r;

    task automatic handle_event(input int kind);
        exp_t e;
        $display("[TB] cyc %0d event %s blue_cnt=%0d red_cnt=%0d cause=%0d",
                 cyc, ev_name(kind), bus.o_blue_cnt, bus.o_red_cnt, bus.o_halt_cause);
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_event: got %s at cyc %0d, expected none", ev_name(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        check("blue_cnt", int'(bus.o_blue_cnt), e.blue);
        check("red_cnt", int'(bus.o_red_cnt), e.red);
        if (kind == EV_HALT) begin
            check("halt_cause", int'(bus.o_halt_cause), e.cause);
            check("in_flight_at_halt", int'(bus.o_in_flight), 0);
        end else begin
            check("in_flight_at_release", int'(bus.o_in_flight), 1);
        end
    endtask

    always @(posedge clk) begin
        #3;
        if (!rst_n) begin
            p_blue = 0; p_red = 0; p_halt = 0; plen_b = 0; plen_r = 0;
        end else begin
            if (bus.o_ball_blue && bus.o_ball_red) check("ball_exclusive", 1, 0);
            if (bus.o_ball_blue && !p_blue) handle_event(EV_BLUE);
            if (bus.o_ball_red && !p_red) handle_event(EV_RED);
            if (bus.o_halt && !p_halt) handle_event(EV_HALT);
            if (p_halt && !bus.o_halt) check("halt_sticky", 0, 1);
            if (bus.o_ball_blue) plen_b++;
            else if (p_blue) begin check("blue_pulse_len", plen_b, PULSE_LEN); plen_b = 0; end
            if (bus.o_ball_red) plen_r++;
            else if (p_red) begin check("red_pulse_len", plen_r, PULSE_LEN); plen_r = 0; end
            p_blue = bus.o_ball_blue; p_red = bus.o_ball_red; p_halt = bus.o_halt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ball_blue", int'(bus.o_ball_blue), 0);
        check("rst_ball_red", int'(bus.o_ball_red), 0);
        check("rst_blue_cnt", int'(bus.o_blue_cnt), N_BLUE);
        check("rst_red_cnt", int'(bus.o_red_cnt), N_RED);
        check("rst_in_flight", int'(bus.o_in_flight), 0);
        check("rst_halt", int'(bus.o_halt), 0);
        check("rst_halt_cause", int'(bus.o_halt_cause), 0);
        rst_n = 1;

        // Game 1: blue start, red trigger, alternate until both empty, then empty halt.
        request(0, 0);
        wait_flight(2);
        check("in_flight_level", int'(bus.o_in_flight), 1);
        request(1, 1);
        for (int i = 0; i < 14; i++) begin
            wait_flight($urandom_range(0, 8));
            request(i % 2, 1);
        end
        wait_flight(1);
        request(0, 1);
        repeat (4) @(negedge clk);
        request(2, 0);
        request(1, 1);
        repeat (4) @(negedge clk);
        check("halt_hold", int'(bus.o_halt), 1);
        check("halt_hold_cause", int'(bus.o_halt_cause), 2);
        drain();

        // Game 2: reset in the middle of a release, then both sides at once, then timeout.
        do_reset();
        request(0, 0);
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        check("midrel_ball_blue", int'(bus.o_ball_blue), 0);
        check("midrel_blue_cnt", int'(bus.o_blue_cnt), N_BLUE);
        check("midrel_red_cnt", int'(bus.o_red_cnt), N_RED);
        check("midrel_in_flight", int'(bus.o_in_flight), 0);
        repeat (2) @(negedge clk);
        rst_n = 1; model_reset();
        request(2, 0);
        wait_flight(3);
        wait_timeout();
        drain();

        // Game 3: red held high through reset counts as a request, then interception.
        @(negedge clk);
        rst_n = 0; clear_inputs(); bus.i_start_right = 1;
        repeat (2) @(negedge clk);
        rst_n = 1; model_reset();
        predict_request(1, cyc);
        repeat (2) @(negedge clk);
        bus.i_start_right = 0;
        wait_flight(4);
        intercept_with_trig();
        repeat (6) @(negedge clk);
        drain();

        // Random games.
        for (int g = 0; g < 8; g++) begin
            do_reset();
            for (int a = 0; a < 40 && !m_halted; a++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 3 && m_flying) wait_timeout();
                else if (r < 8 && m_flying) intercept_with_trig();
                else request($urandom_range(0, 2), 1'($urandom_range(0, 1)));
                wait_flight($urandom_range(0, 8));
            end
            repeat (6) @(negedge clk);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
